// File: rtl/img_reader.sv
// Frame-buffer raster reader: streams WIDTH*HEIGHT pixels with sof/eol/eof
// tags through a 2-entry output FIFO under valid/ready backpressure.
module img_reader #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int BIT_WIDTH = 8,
  localparam int AW = $clog2(WIDTH*HEIGHT)+1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [AW-1:0]        r_addr,
  input  logic [BIT_WIDTH-1:0] rd_data,
  output logic [BIT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic                 m_eof,
  output logic                 busy,
  output logic                 done
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int EW = BIT_WIDTH + 3;
  localparam logic [AW-1:0] LAST = AW'(WIDTH*HEIGHT-1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      tag_q, tag_d;
  logic            vld_q, vld_d;
  logic [EW-1:0]   mem_q [2];
  logic [EW-1:0]   mem_d [2];
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            push, pop, room;
  logic            sof, eol, eof;
  logic [2:0]      occ;
  logic [EW-1:0]   head;

  always_comb begin
    head  = mem_q[rp_q];
    push  = vld_q;
    pop   = (cnt_q != 2'd0) && m_ready;
    // Entries that will exist once the bus word lands; one more read fits below 2
    occ   = 3'(cnt_q) + 3'(push) - 3'(pop);
    room  = occ < 3'd2;
    rd_en = !rst && (state_q == READ) && room;

    sof = (x_q == '0) && (y_q == '0);
    eol = (x_q == XW'(WIDTH-1));
    eof = eol && (y_q == YW'(HEIGHT-1));

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    vld_d   = rd_en;
    tag_d   = rd_en ? {sof, eol, eof} : tag_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      READ: begin
        if (rd_en) begin
          if (addr_q == LAST) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
          if (eol) begin
            x_d = '0;
            y_d = eof ? '0 : y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (pop && head[0]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = {rd_data, tag_q};
      wp_d        = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      vld_q   <= 1'b0;
      mem_q   <= '{default: '0};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      vld_q   <= vld_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign r_addr  = addr_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head[EW-1:3];
  assign m_sof   = head[2];
  assign m_eol   = head[1];
  assign m_eof   = head[0];
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_img_reader.sv
// Directed bench for img_reader on a 4x2 frame; memory returns data = address.
module tb_img_reader;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int BW = 8;
  localparam int AW = $clog2(W*H)+1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] rd_data = '0;
  logic [BW-1:0] m_data;
  logic          m_valid, m_sof, m_eol, m_eof, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  img_reader #(.WIDTH(W), .HEIGHT(H), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .r_addr(r_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    if (rd_en) rd_data <= BW'(r_addr);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rdy, input logic st);
    @(posedge clk);
    #1;
    m_ready = rdy;
    start   = st;
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " m_valid"}, m_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " r_addr"}, r_addr, 0);
    chk({tag, " m_data"}, m_data, 0);
    chk({tag, " tags"}, {m_sof, m_eol, m_eof}, 0);
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1 pattern; 2: ready low for 8 cycles
  task automatic frame(input int mode, input bit repulse);
    int  exp_px, issued, popped, dones, post;
    bit  stall, pulsed, pop_now;
    logic [BW-1:0] pdata;
    logic [2:0]    ptag;
    logic rdy;
    exp_px = 0; issued = 0; popped = 0; dones = 0; post = 0;
    stall = 0; pulsed = 0; pdata = '0; ptag = '0;
    cyc(mode != 2, 1'b1);
    for (int i = 1; i < 80; i++) begin
      case (mode)
        1:       rdy = (i % 4 == 0) || (i % 4 == 3);
        2:       rdy = (i > 8);
        default: rdy = 1'b1;
      endcase
      cyc(rdy, repulse && !pulsed && exp_px == 3);
      if (start) pulsed = 1;
      pop_now = m_valid && m_ready;
      if (stall) begin
        chk("stall valid", m_valid, 1);
        chk("stall data", m_data, pdata);
        chk("stall tags", {m_sof, m_eol, m_eof}, ptag);
      end
      if (rd_en) begin
        chk("rd addr", r_addr, issued);
        chk("outstanding", (issued - popped - int'(pop_now)) <= 1, 1);
        issued++;
      end
      if (mode == 2 && i == 8) chk("reads while stalled", issued, 2);
      if (pop_now) begin
        chk("px data", m_data, exp_px);
        chk("px sof", m_sof, exp_px == 0);
        chk("px eol", m_eol, exp_px % W == W-1);
        chk("px eof", m_eof, exp_px == W*H-1);
        exp_px++;
        popped++;
      end
      if (done) begin
        dones++;
        chk("done after last px", exp_px, W*H);
        chk("busy at done", busy, 0);
      end
      stall = m_valid && !m_ready;
      pdata = m_data;
      ptag  = {m_sof, m_eol, m_eof};
      if (dones > 0) post++;
      if (post > 4) break;
    end
    chk("frame pixels", exp_px, W*H);
    chk("frame reads", issued, W*H);
    chk("frame dones", dones, 1);
    chk("idle after frame", busy, 0);
  endtask

  initial begin
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_reset_outs("reset");

    // exact cycle timing with ready held high
    cyc(1'b1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("c%0d busy", c), busy, c <= 10);
      chk($sformatf("c%0d done", c), done, c == 11);
      chk($sformatf("c%0d valid", c), m_valid, c >= 3 && c <= 10);
      chk($sformatf("c%0d rd_en", c), rd_en, c <= 8);
      if (c <= 8) chk($sformatf("c%0d addr", c), r_addr, c-1);
      if (c >= 9) chk($sformatf("c%0d addr hold", c), r_addr, 7);
      if (c >= 3 && c <= 10) begin
        chk($sformatf("c%0d data", c), m_data, c-3);
        chk($sformatf("c%0d sof", c), m_sof, c == 3);
        chk($sformatf("c%0d eol", c), m_eol, c == 6 || c == 10);
        chk($sformatf("c%0d eof", c), m_eof, c == 10);
      end
    end

    frame(1, 1'b0);
    frame(2, 1'b0);
    frame(0, 1'b1);

    // reset mid-frame right after pixel 4 transfers
    cyc(1'b1, 1'b1);
    for (int c = 1; c <= 7; c++) cyc(1'b1, 1'b0);
    chk("pre-rst px4", m_data, 4);
    chk("pre-rst valid", m_valid, 1);
    cyc(1'b1, 1'b0);
    rst = 1'b1;
    #1 chk("rd_en in rst", rd_en, 0);
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    #1 chk_reset_outs("mid-rst");
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, 1'b0);
      chk("quiet rd_en", rd_en, 0);
      chk("quiet valid", m_valid, 0);
      chk("quiet busy", busy, 0);
    end
    frame(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/img_reader.md
IMG_READER -- requirements
Module: img_reader

Interface
REQ-001: WIDTH, 640, pixels per line.
REQ-002: HEIGHT, 480, lines per frame.
REQ-003: BIT_WIDTH, 8, bits per gray-scale pixel.
REQ-004: AW (localparam) SHALL equal $clog2(WIDTH*HEIGHT)+1, the frame-buffer address width.
REQ-005: clk  input  1  single clock; all logic on rising edge.
REQ-006: rst  input  1  synchronous, active-high reset.
REQ-007: start  input  1  one-cycle pulse requesting readout of one full frame.
REQ-008: rd_en  output  1  read enable to the frame-buffer read port.
REQ-009: r_addr  output  AW  read address to the frame buffer, registered.
REQ-010: rd_data  input  BIT_WIDTH  frame-buffer read data, valid exactly 1 cycle after the rd_en cycle.
REQ-011: m_data  output  BIT_WIDTH  output pixel.
REQ-012: m_valid  output  1  m_data and sideband valid.
REQ-013: m_ready  input  1  downstream accepts; transfer when m_valid && m_ready.
REQ-014: m_sof  output  1  first pixel of frame (x=0, y=0).
REQ-015: m_eol  output  1  last pixel of a line (x=WIDTH-1).
REQ-016: m_eof  output  1  last pixel of frame (x=WIDTH-1, y=HEIGHT-1).
REQ-017: busy  output  1  frame readout in progress.
REQ-018: done  output  1  one-cycle pulse after the last pixel transfers.

Function
REQ-019: FSM states SHALL be IDLE, READ, DRAIN.
REQ-020: IDLE -> READ on start; busy SHALL go high the cycle after start is sampled.
REQ-021: In READ, addresses 0..WIDTH*HEIGHT-1 SHALL be issued once each, in ascending raster order, one per rd_en cycle.
REQ-022: READ -> DRAIN in the cycle after the read of address WIDTH*HEIGHT-1 is issued.
REQ-023: DRAIN -> IDLE when the m_eof pixel transfers; done SHALL pulse high in the following cycle, coincident with busy falling.
REQ-024: start SHALL be ignored while busy is high.
REQ-025: Output buffering SHALL be a 2-entry FIFO holding {pixel, sof, eol, eof}; m_* SHALL be driven from its head.
REQ-026: rd_en SHALL be asserted only when (FIFO occupancy + reads in flight - pop this cycle) < 2, so no returned pixel is ever dropped.
REQ-027: With m_ready held high, throughput SHALL be 1 pixel per cycle with no bubbles after the first pixel.
REQ-028: Latency: start in cycle 0 -> rd_en=1, r_addr=0 in cycle 1 -> rd_data in cycle 2 -> m_valid=1 in cycle 3.
REQ-029: Once asserted, m_valid and m_data/sideband SHALL remain stable until transfer.
REQ-030: x (0..WIDTH-1) and y (0..HEIGHT-1) counters SHALL advance per issued read; x wraps to 0 and y increments at WIDTH-1; sideband tags SHALL be computed at issue and travel with the pixel.
REQ-031: rd_en SHALL be low and r_addr SHALL hold its last value in IDLE and DRAIN.
REQ-032: A simultaneous push (returning read) and pop (transfer) on a full FIFO SHALL keep occupancy unchanged.

Reset
REQ-033: rst SHALL force state IDLE, FIFO empty, x=y=0, r_addr=0, rd_en=0, m_valid=0, m_sof=m_eol=m_eof=0, m_data=0, busy=0, done=0.
REQ-034: rst asserted mid-frame SHALL abort the frame; in-flight read data arriving in the cycle after rst SHALL be discarded.
REQ-035: After rst deasserts, no activity SHALL occur until a new start.

Verification (WIDTH=4, HEIGHT=2, memory model returns data = address)
REQ-036: start, m_ready=1 -> m_valid first high cycle 3; data 0..7 on 8 consecutive cycles; m_sof on 0; m_eol on 3 and 7; m_eof on 7; done one cycle after pixel 7.
REQ-037: m_ready toggled 1,0,0,1,... -> every pixel 0..7 delivered exactly once, in order, held stable during stalls; rd_en never issues a 3rd outstanding pixel.
REQ-038: m_ready=0 from start -> exactly 2 reads issued (addr 0,1), then rd_en low until m_ready rises.
REQ-039: start re-pulsed at pixel 3 -> ignored; frame completes normally with one done pulse.
REQ-040: rst asserted after pixel 4 transfers -> all outputs at reset values next cycle; subsequent start yields fresh frame beginning with data 0 and m_sof.
